// File: rtl/serial_code_converter.sv
// serial_code_converter: serial-in word of packed decimal digits, converted
// per digit XS3<->BCD with per-digit error flags and a one-cycle valid pulse.
module serial_code_converter #(
  parameter int DIGITS    = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  sync,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  output logic                  busy
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, idx, pos;
  logic [W-1:0]  sr, sr_d, word, data_d;
  logic [DIGITS-1:0] err_d;
  logic          mode_q, mode_d, start, last;

  function automatic logic [4:0] conv(input logic [3:0] d, input logic m);
    if (m) return d <= 4'd9 ? {1'b0, d + 4'd3} : 5'h10;
    return (d >= 4'd3 && d <= 4'd12) ? {1'b0, d - 4'd3} : 5'h10;
  endfunction

  // A bit outside SHIFT, or any bit with sync, opens a new word.
  always_comb begin
    start = bit_valid && (sync || state != SHIFT);
    last  = bit_valid && !sync && state == SHIFT && cnt == CW'(W - 1);
    idx   = start ? '0 : cnt;
    pos   = LSB_FIRST ? idx : CW'(W - 1) - idx;
    word  = start ? '0 : sr;
    word[pos] = bit_in;
    data_d = '0;
    err_d  = '0;
    for (int k = 0; k < DIGITS; k++)
      {err_d[k], data_d[4*k +: 4]} = conv(word[4*k +: 4], mode_q);
    state_d = state == OUT ? IDLE : state;
    cnt_d   = cnt;
    sr_d    = sr;
    mode_d  = mode_q;
    if (sync && !bit_valid) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (start) begin
      state_d = SHIFT;
      cnt_d   = CW'(1);
      sr_d    = word;
      mode_d  = mode;
    end else if (last) begin
      state_d = OUT;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (bit_valid) begin
      cnt_d = cnt + CW'(1);
      sr_d  = word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      mode_q   <= 1'b0;
      out_data <= '0;
      out_err  <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      sr     <= sr_d;
      mode_q <= mode_d;
      if (last) begin
        out_data <= data_d;
        out_err  <= err_d;
      end
    end
  end

  assign out_valid = state == OUT;
  assign busy      = state == SHIFT;
endmodule

// File: tb/tb_serial_code_converter.sv
// tb_serial_code_converter: LSB-first and MSB-first instances share one
// serial stream; a queue-based model predicts every output on every cycle.
module tb_serial_code_converter;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, sync = 1'b0;
  logic [W-1:0] data_a, data_b;
  logic [3:0]   err_a, err_b;
  logic         valid_a, valid_b, busy_a, busy_b;
  int checks = 0, errors = 0, pulses = 0;
  logic q[$];
  logic mm = 1'b0, ev = 1'b0;
  logic [15:0] ed_a = '0, ed_b = '0;
  logic [3:0]  ee_a = '0, ee_b = '0;
  typedef struct {logic [15:0] w; logic m; logic [15:0] d; logic [3:0] e;} vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  serial_code_converter #(.DIGITS(4), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .bit_in(bit_in), .bit_valid(bit_valid),
    .sync(sync), .out_data(data_a), .out_err(err_a), .out_valid(valid_a), .busy(busy_a));
  serial_code_converter #(.DIGITS(4), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .bit_in(bit_in), .bit_valid(bit_valid),
    .sync(sync), .out_data(data_b), .out_err(err_b), .out_valid(valid_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] mconv(input logic [15:0] w, input logic m);
    int d;
    logic [15:0] o = '0;
    logic [3:0]  e = '0;
    for (int k = 0; k < 4; k++) begin
      d = int'(w >> (4 * k)) & 15;
      if (m ? d <= 9 : (d >= 3 && d <= 12)) o = o | 16'((m ? d + 3 : d - 3) << (4 * k));
      else e[k] = 1'b1;
    end
    return {e, o};
  endfunction

  task automatic model_step();
    logic [15:0] wa, wb;
    ev = 1'b0;
    if (sync) q.delete();
    if (bit_valid) begin
      if (q.size() == 0) mm = mode;
      q.push_back(bit_in);
      if (q.size() == W) begin
        for (int n = 0; n < W; n++) begin
          wa[n] = q[n];
          wb[W-1-n] = q[n];
        end
        {ee_a, ed_a} = mconv(wa, mm);
        {ee_b, ed_b} = mconv(wb, mm);
        ev = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic compare_all();
    chk("valid_a", valid_a, ev);
    chk("valid_b", valid_b, ev);
    chk("busy_a", busy_a, q.size() != 0);
    chk("busy_b", busy_b, q.size() != 0);
    chk("data_a", data_a, ed_a);
    chk("err_a", err_a, ee_a);
    chk("data_b", data_b, ed_b);
    chk("err_b", err_b, ee_b);
  endtask

  task automatic cyc(input logic v, input logic b, input logic s, input logic m);
    bit_valid = v;
    bit_in    = b;
    sync      = s;
    mode      = m;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (valid_a) pulses++;
  endtask

  task automatic send_word(input logic [15:0] w, input logic m, input logic msb,
                           input logic s, input logic tog);
    for (int n = 0; n < W; n++)
      cyc(1'b1, msb ? w[15-n] : w[n], s && n == 0, (tog && n >= 5) ? ~m : m);
  endtask

  initial begin
    logic [15:0] w1, w2, wr;
    logic [19:0] r;
    logic m;
    tbl[0] = '{16'h8C53, 1'b0, 16'h5920, 4'h0};
    tbl[1] = '{16'h1987, 1'b1, 16'h4CBA, 4'h0};
    tbl[2] = '{16'h0F33, 1'b0, 16'h0000, 4'hC};
    tbl[3] = '{16'hA009, 1'b1, 16'h033C, 4'h8};
    tbl[4] = '{16'hC3C3, 1'b0, 16'h9090, 4'h0};
    tbl[5] = '{16'h9090, 1'b1, 16'hC3C3, 4'h0};
    tbl[6] = '{16'hFFFF, 1'b1, 16'h0000, 4'hF};
    tbl[7] = '{16'h2D21, 1'b0, 16'h0000, 4'hF};
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) begin
        send_word(tbl[i].w, tbl[i].m, p == 1, 1'b0, 1'b0);
        chk("tbl_valid", p == 1 ? valid_b : valid_a, 1'b1);
        chk("tbl_data", p == 1 ? data_b : data_a, tbl[i].d);
        chk("tbl_err", p == 1 ? err_b : err_a, tbl[i].e);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
    pulses = 0;
    for (int n = 0; n < 7; n++) cyc(1'b1, 1'($urandom), 1'b0, 1'b1);
    send_word(16'h8C53, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sync_pulses", pulses, 1);
    chk("sync_data", data_a, 16'h5920);
    pulses = 0;
    for (int n = 0; n < 15; n++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
    send_word(16'h1987, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sync_last_pulses", pulses, 1);
    chk("sync_last_data", data_a, 16'h4CBA);
    for (int n = 0; n < 5; n++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sync_idle_busy", busy_a, 1'b0);
    wr = 16'h8C53;
    for (int n = 0; n < 10; n++) cyc(1'b1, wr[n], 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", data_a, 16'h0);
    chk("rst_err", err_a, 4'h0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_valid", valid_a, 1'b0);
    q.delete();
    ev = 1'b0; ed_a = '0; ed_b = '0; ee_a = '0; ee_b = '0;
    @(posedge clk);
    #1;
    compare_all();
    bit_valid = 1'b0;
    #2 rst_n = 1'b1;
    send_word(16'h8C53, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", data_a, 16'h5920);
    for (int t = 0; t < 4; t++) begin
      pulses = 0;
      w1 = 16'($urandom);
      w2 = 16'($urandom);
      m  = 1'($urandom);
      for (int n = 0; n < W; n++) begin
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom), 1'b0, ~m);
        cyc(1'b1, w1[n], 1'b0, m);
      end
      send_word(w2, m, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      r = mconv(w2, m);
      chk("b2b_pulses", pulses, 2);
      chk("b2b_data", data_a, r[15:0]);
      chk("b2b_err", err_a, r[19:16]);
    end
    repeat (3000)
      cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 39) == 0, 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
